// File: rtl/rsh_one_pkg.sv
// Shared width, word type and constants for the single-bit right shifter.
package rsh_one_pkg;

   localparam int unsigned N = 4;
   localparam int unsigned W = 2 ** N;

   typedef logic [W-1:0] rsh_word_t;

   localparam rsh_word_t RSH_ZERO = '0;

endpackage : rsh_one_pkg

// File: rtl/rsh_one_shifter_if.sv
// Operand/result bus of the right shifter; the shout bit is only present
// when RSH_ONE_SHOUT_EN is defined.
interface rsh_one_shifter_if;
   import rsh_one_pkg::*;

   rsh_word_t a;
   logic      in_valid;
   logic      arith;
   rsh_word_t b;
   logic      out_valid;
`ifdef RSH_ONE_SHOUT_EN
   logic      shout;

   modport master (output a, output in_valid, output arith,
                   input  b, input  out_valid, input  shout);
   modport slave  (input  a, input  in_valid, input  arith,
                   output b, output out_valid, output shout);
`else
   modport master (output a, output in_valid, output arith,
                   input  b, input  out_valid);
   modport slave  (input  a, input  in_valid, input  arith,
                   output b, output out_valid);
`endif

endinterface : rsh_one_shifter_if

// File: rtl/rsh_one_core.sv
// Combinational one-bit right shift: logical or sign-filling, plus the bit
// that falls off the LSB end.
module rsh_one_core
   import rsh_one_pkg::*;
(
   input  rsh_word_t i_a,
   input  logic      i_arith,
   output rsh_word_t o_r_c,
   output logic      o_lsb_c
);

   // Fill bit is the MSB only when sign extension is requested
   always_comb begin
      o_r_c   = {i_arith & i_a[W-1], i_a[W-1:1]};
      o_lsb_c = i_a[0];
   end

endmodule : rsh_one_core

// File: rtl/rsh_one_shifter.sv
// Registered single-bit right shifter, one-cycle latency, one word per cycle.
// Define RSH_ONE_SHOUT_EN to add the registered shifted-out bit (bus.shout).
module rsh_one_shifter
   import rsh_one_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   rsh_one_shifter_if.slave    bus
);

   rsh_word_t w_r;
   logic      w_lsb;
   rsh_word_t r_b;
   logic      r_out_valid;

   rsh_one_core u_core (
      .i_a     (bus.a),
      .i_arith (bus.arith),
      .o_r_c   (w_r),
      .o_lsb_c (w_lsb)
   );

   // Result register updates only on valid words so idle/X inputs never reach b
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b         <= RSH_ZERO;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_b <= w_r;
         end
      end
   end

   assign bus.b         = r_b;
   assign bus.out_valid = r_out_valid;

`ifdef RSH_ONE_SHOUT_EN
   logic r_shout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shout <= 1'b0;
      end else if (bus.in_valid) begin
         r_shout <= w_lsb;
      end
   end

   assign bus.shout = r_shout;
`else
   logic w_unused_lsb;
   assign w_unused_lsb = w_lsb;
`endif

endmodule : rsh_one_shifter

// File: tb/tb_rsh_one_shifter.sv
// Scoreboard bench for rsh_one_shifter: expected words are queued at drive
// time and compared when the registered result appears.
module tb_rsh_one_shifter;
   import rsh_one_pkg::*;

   typedef struct packed {
      rsh_word_t b;
      logic      shout;
   } exp_t;

   logic clk;
   logic rst_n = 1'b1;

   rsh_one_shifter_if bus ();

   rsh_one_shifter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   exp_t        sb_q[$];
   rsh_word_t   last_b     = RSH_ZERO;
   logic        last_shout = 1'b0;

   task automatic chk(input string tag, input rsh_word_t got, input rsh_word_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic rsh_word_t model(input rsh_word_t a, input logic arith);
      rsh_word_t res;
      res = a >> 1;
      if (arith && a[W-1]) res[W-1] = 1'b1;
      return res;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_b"}, bus.b, RSH_ZERO);
      chk({tag, "_ov"}, rsh_word_t'(bus.out_valid), rsh_word_t'(1'b0));
`ifdef RSH_ONE_SHOUT_EN
      chk({tag, "_shout"}, rsh_word_t'(bus.shout), rsh_word_t'(1'b0));
`endif
   endtask

   // Drive one cycle, then compare the result produced by that edge
   task automatic step(input string tag, input rsh_word_t a, input logic arith,
                       input logic valid, input rsh_word_t exp_b);
      exp_t e;
      bus.a        = a;
      bus.arith    = arith;
      bus.in_valid = valid;
      if (valid) sb_q.push_back({exp_b, a[0]});
      @(posedge clk);
      #1;
      chk({tag, "_ov"}, rsh_word_t'(bus.out_valid), rsh_word_t'(valid));
      if (valid) begin
         if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, rsh_word_t'(1'b1), rsh_word_t'(1'b0));
         end else begin
            e = sb_q.pop_front();
            chk({tag, "_b"}, bus.b, e.b);
`ifdef RSH_ONE_SHOUT_EN
            chk({tag, "_shout"}, rsh_word_t'(bus.shout), rsh_word_t'(e.shout));
`endif
            last_b     = e.b;
            last_shout = e.shout;
         end
      end else begin
         chk({tag, "_hold_b"}, bus.b, last_b);
`ifdef RSH_ONE_SHOUT_EN
         chk({tag, "_hold_shout"}, rsh_word_t'(bus.shout), rsh_word_t'(last_shout));
`endif
      end
   endtask

   initial begin
      rsh_word_t ra;
      logic      rar;
      bus.a        = RSH_ZERO;
      bus.arith    = 1'b0;
      bus.in_valid = 1'b0;

      // Asynchronous reset with random activity on the inputs
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_async");
      for (int i = 0; i < 3; i++) begin
         bus.a        = rsh_word_t'($urandom);
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.arith    = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1 check_reset_outputs("rst_clk");
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;

      // Directed cases
      step("logical",   16'h0013, 1'b0, 1'b1, 16'h0009);
      step("lsr_neg",   16'hFFFB, 1'b0, 1'b1, 16'h7FFD);
      step("asr_neg",   16'hFFFB, 1'b1, 1'b1, 16'hFFFD);
      step("ones_lsr",  16'hFFFF, 1'b0, 1'b1, 16'h7FFF);
      step("ones_asr",  16'hFFFF, 1'b1, 1'b1, 16'hFFFF);
      step("asr_pos",   16'h7FFE, 1'b1, 1'b1, 16'h3FFF);
      step("one_lost",  16'h0001, 1'b1, 1'b1, 16'h0000);

      // Hold with X on an idle bus
      step("hold_load", 16'h0010, 1'b0, 1'b1, 16'h0008);
      for (int i = 0; i < 3; i++) step("hold", 'x, 1'b0, 1'b0, RSH_ZERO);

      // Back-to-back streaming
      step("s0", 16'h0000, 1'b0, 1'b1, 16'h0000);
      step("s1", 16'h0001, 1'b0, 1'b1, 16'h0000);
      step("s2", 16'h0008, 1'b0, 1'b1, 16'h0004);
      step("s3", 16'h000E, 1'b0, 1'b1, 16'h0007);
      step("s4", 16'hFFEE, 1'b0, 1'b1, 16'h7FF7);
      step("s5", 16'h8000, 1'b0, 1'b1, 16'h4000);

      // Random words with occasional bubbles
      for (int i = 0; i < 20; i++) begin
         ra  = rsh_word_t'($urandom);
         rar = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) step("rnd_idle", ra, rar, 1'b0, RSH_ZERO);
         else                           step("rnd", ra, rar, 1'b1, model(ra, rar));
      end

      // Reset in the middle of a stream
      step("m0", 16'h1234, 1'b0, 1'b1, 16'h091A);
      bus.a        = 16'hABCD;
      bus.arith    = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      sb_q.delete();
      last_b     = RSH_ZERO;
      last_shout = 1'b0;
      @(posedge clk);
      #1 check_reset_outputs("mid_rst_clk");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst",  16'h0013, 1'b0, 1'b1, 16'h0009);
      step("post_asr",  16'h8003, 1'b1, 1'b1, 16'hC001);
      step("post_idle", 16'h5555, 1'b0, 1'b0, RSH_ZERO);

      chk("sb_drained", rsh_word_t'(sb_q.size()), RSH_ZERO);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_rsh_one_shifter
